// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall control and the
// IF/ID pipeline register, plus a sticky misaligned-target flag and a fetch counter.
module pc_fetch_stage #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0,
  parameter logic [WIDTH-1:0]   NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [WIDTH-1:0] PCPlus4F,
  input  logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD,
  output logic             MisalignF,
  output logic [WIDTH-1:0] FetchCnt
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr_d;
  logic [WIDTH-1:0] r_pc_d;
  logic [WIDTH-1:0] r_pc_plus4_d;
  logic             r_valid_d;
  logic             r_misalign;
  logic [WIDTH-1:0] r_fetch_cnt;

  logic             w_load_d;
  logic [WIDTH-1:0] w_target_aligned;

  assign w_load_d         = !FlushD && !StallD;
  // Redirect targets are forced word-aligned; the low bits only feed MisalignF.
  assign w_target_aligned = {PCTargetE[WIDTH-1:2], 2'b00};

  // A redirect wins over StallF so a taken branch is never lost behind a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (PCSrcE) begin
      r_pc <= w_target_aligned;
    end else if (!StallF) begin
      r_pc <= PCPlus4F;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (!StallD) begin
      r_instr_d    <= InstrF;
      r_pc_d       <= r_pc;
      r_pc_plus4_d <= PCPlus4F;
      r_valid_d    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  // Counts IF/ID loads only; wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
    end else if (w_load_d) begin
      r_fetch_cnt <= r_fetch_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign PCF       = r_pc;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pc_plus4_d;
  assign ValidD    = r_valid_d;
  assign MisalignF = r_misalign;
  assign FetchCnt  = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed vector table on a 32-bit instance plus
// hand-written sequences for sticky misalign, reset timing and counter wrap (8-bit).
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        reset = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] PCPlus4F, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCnt;
  logic        ValidD, MisalignF;

  // Instruction memory model: word at address p reads as 0xAB000000 | p.
  assign PCPlus4F = PCF + 32'd4;
  assign InstrF   = 32'hAB00_0000 | PCF;

  pc_fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .MisalignF(MisalignF), .FetchCnt(FetchCnt)
  );

  // 8-bit instance for counter wrap
  logic       reset8 = 1'b1;
  logic [7:0] pc8, instr8_d, pcd8, pcp4d8, cnt8;
  logic [7:0] pcp4f8, instrf8;
  logic       valid8, mis8;
  logic       zero8 = 1'b0;
  logic [7:0] tgt8 = '0;

  assign pcp4f8  = pc8 + 8'd4;
  assign instrf8 = pc8;

  pc_fetch_stage #(.WIDTH(8), .RESET_PC(8'h00), .NOP_INSTR(8'h13)) dut8 (
    .clk(clk), .reset(reset8), .StallF(zero8), .StallD(zero8), .FlushD(zero8),
    .PCSrcE(zero8), .PCTargetE(tgt8), .PCPlus4F(pcp4f8), .InstrF(instrf8),
    .PCF(pc8), .InstrD(instr8_d), .PCD(pcd8), .PCPlus4D(pcp4d8), .ValidD(valid8),
    .MisalignF(mis8), .FetchCnt(cnt8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, sf, sd, fd, ps;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_instr, e_pcd, e_p4d;
    logic        e_v, e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_pcd, input logic [31:0] e_p4d, input logic e_v,
                         input logic e_mis, input logic [31:0] e_cnt);
    chk({tag, " PCF"}, PCF, e_pc);
    chk({tag, " InstrD"}, InstrD, e_instr);
    chk({tag, " PCD"}, PCD, e_pcd);
    chk({tag, " PCPlus4D"}, PCPlus4D, e_p4d);
    chk({tag, " ValidD"}, {31'd0, ValidD}, {31'd0, e_v});
    chk({tag, " MisalignF"}, {31'd0, MisalignF}, {31'd0, e_mis});
    chk({tag, " FetchCnt"}, FetchCnt, e_cnt);
  endtask

  initial begin
    //          rst sf sd fd ps  tgt      pcf      instrD         pcd      p4d     v  mis cnt
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h13,        32'h0,   32'h0,   0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,   32'h4,   32'hAB000000,  32'h0,   32'h4,   1, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,   32'h8,   32'hAB000004,  32'h4,   32'h8,   1, 0, 2};
    vecs[3]  = '{0, 1, 1, 0, 0, 32'h0,   32'h8,   32'hAB000004,  32'h4,   32'h8,   1, 0, 2};
    vecs[4]  = '{0, 1, 1, 0, 0, 32'h0,   32'h8,   32'hAB000004,  32'h4,   32'h8,   1, 0, 2};
    vecs[5]  = '{0, 0, 0, 0, 0, 32'h0,   32'hC,   32'hAB000008,  32'h8,   32'hC,   1, 0, 3};
    vecs[6]  = '{0, 1, 0, 1, 1, 32'h100, 32'h100, 32'h13,        32'h0,   32'h0,   0, 0, 3};
    vecs[7]  = '{0, 0, 0, 0, 0, 32'h0,   32'h104, 32'hAB000100,  32'h100, 32'h104, 1, 0, 4};
    vecs[8]  = '{0, 0, 1, 1, 0, 32'h0,   32'h108, 32'h13,        32'h0,   32'h0,   0, 0, 4};
    vecs[9]  = '{0, 0, 1, 0, 0, 32'h0,   32'h10C, 32'h13,        32'h0,   32'h0,   0, 0, 4};
    vecs[10] = '{0, 0, 0, 0, 1, 32'h206, 32'h204, 32'hAB00010C,  32'h10C, 32'h110, 1, 1, 5};
    vecs[11] = '{0, 0, 0, 0, 0, 32'h0,   32'h208, 32'hAB000204,  32'h204, 32'h208, 1, 1, 6};
    vecs[12] = '{0, 1, 0, 0, 0, 32'h0,   32'h208, 32'hAB000208,  32'h208, 32'h20C, 1, 1, 7};
    vecs[13] = '{0, 1, 0, 0, 1, 32'h3,   32'h0,   32'hAB000208,  32'h208, 32'h20C, 1, 1, 8};

    #1;
    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst; StallF = vecs[i].sf; StallD = vecs[i].sd;
      FlushD = vecs[i].fd; PCSrcE = vecs[i].ps; PCTargetE = vecs[i].tgt;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcd,
              vecs[i].e_p4d, vecs[i].e_v, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // Free-run 10 cycles from PCF=0: MisalignF must stay set.
    reset = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("run%0d PCF", k), PCF, 32'(4 * k));
      chk($sformatf("run%0d InstrD", k), InstrD, 32'hAB00_0000 | 32'(4 * (k - 1)));
      chk($sformatf("run%0d MisalignF", k), {31'd0, MisalignF}, 32'd1);
      chk($sformatf("run%0d FetchCnt", k), FetchCnt, 32'(8 + k));
    end

    // Reset raised between edges must not disturb outputs.
    reset = 1;
    #2;
    chk("async_rst PCF", PCF, 32'h28);
    chk("async_rst MisalignF", {31'd0, MisalignF}, 32'd1);
    chk("async_rst FetchCnt", FetchCnt, 32'd18);
    chk("async_rst ValidD", {31'd0, ValidD}, 32'd1);

    // Reset overrides stall and redirect on the same edge.
    StallF = 1; StallD = 1; PCSrcE = 1; PCTargetE = 32'h51;
    step();
    chk_all("rst_ovr", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    reset = 0; StallF = 0; StallD = 0; PCSrcE = 0; PCTargetE = '0;
    step();
    chk_all("post_rst", 32'h4, 32'hAB000000, 32'h0, 32'h4, 1'b1, 1'b0, 32'h1);

    // Counter wrap on the 8-bit instance.
    chk("w8 reset cnt", {24'd0, cnt8}, 32'h0);
    chk("w8 reset instr", {24'd0, instr8_d}, 32'h13);
    reset8 = 0;
    for (int k = 0; k < 255; k++) step();
    chk("w8 cnt 255", {24'd0, cnt8}, 32'hFF);
    chk("w8 pc 255", {24'd0, pc8}, 32'hFC);
    step();
    chk("w8 cnt wrap", {24'd0, cnt8}, 32'h0);
    chk("w8 pc wrap", {24'd0, pc8}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
- REQ-001: Parameter WIDTH, default 32, SHALL set the datapath width of all PC, instruction and counter signals.
- REQ-002: Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
- REQ-003: Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the InstrD value inserted on reset or flush.
- REQ-004: clk  in  1  single clock; all state SHALL update on its rising edge only.
- REQ-005: reset  in  1  synchronous, active-high reset.
- REQ-006: StallF  in  1  hold PC register.
- REQ-007: StallD  in  1  hold IF/ID register.
- REQ-008: FlushD  in  1  bubble IF/ID register.
- REQ-009: PCSrcE  in  1  taken branch/jump redirect request.
- REQ-010: PCTargetE  in  WIDTH  redirect target address.
- REQ-011: PCPlus4F  in  WIDTH  PCF+4, supplied by the external +4 adder.
- REQ-012: InstrF  in  WIDTH  instruction word read combinationally from instruction memory at PCF.
- REQ-013: PCF  out  WIDTH  current fetch PC, driven to the adder and instruction memory.
- REQ-014: InstrD, PCD, PCPlus4D  out  WIDTH each  IF/ID register contents.
- REQ-015: ValidD  out  1  IF/ID holds a real fetched instruction.
- REQ-016: MisalignF  out  1  sticky flag, redirect target had bits [1:0] != 0.
- REQ-017: FetchCnt  out  WIDTH  count of instructions loaded into IF/ID.

Function
- REQ-018: The PC register SHALL update with this priority: reset -> RESET_PC; else PCSrcE=1 -> {PCTargetE[WIDTH-1:2],2'b00}; else StallF=1 -> hold; else -> PCPlus4F.
- REQ-019: PCSrcE SHALL override StallF when both are 1 in the same cycle.
- REQ-020: PCF SHALL be the PC register output directly; fetch latency SHALL be 0 cycles from PC register to PCF.
- REQ-021: The IF/ID register SHALL update with this priority: reset or FlushD -> InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0; else StallD=1 -> hold all four; else -> InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
- REQ-022: FlushD SHALL override StallD when both are 1.
- REQ-023: An instruction presented on InstrF SHALL appear on InstrD exactly 1 cycle later when StallD=0 and FlushD=0.
- REQ-024: MisalignF SHALL set on the clock edge where PCSrcE=1 and PCTargetE[1:0]!=0, and SHALL remain set until reset.
- REQ-025: FetchCnt SHALL increment by 1 on each edge where IF/ID loads (reset=0, FlushD=0, StallD=0), and SHALL wrap from all-ones to 0 without any flag.
- REQ-026: PC arithmetic SHALL wrap modulo 2^WIDTH; no overflow detection is required.
- REQ-027: No output SHALL depend combinationally on any input except through registered state.

Reset
- REQ-028: While reset=1 at a clock edge: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignF=0, FetchCnt=0.
- REQ-029: Reset SHALL override StallF, StallD, FlushD and PCSrcE, including reset asserted mid-stall or mid-redirect.
- REQ-030: Reset asserted without a clock edge SHALL NOT change any output.

Verification
- REQ-031: Reset then 3 free-running cycles with PCPlus4F=PCF+4 -> PCF = 0,4,8,12; PCD lags by 1 cycle; ValidD=1 from cycle 2; FetchCnt=3.
- REQ-032: StallF=StallD=1 for 2 cycles at PCF=8 -> PCF, InstrD, PCD, FetchCnt held; resume -> PCF=12 next edge.
- REQ-033: PCSrcE=1, PCTargetE=32'h0000_0100, StallF=1 same cycle -> PCF=32'h100 next edge; FlushD=1 same cycle -> InstrD=32'h13, ValidD=0.
- REQ-034: PCSrcE=1, PCTargetE=32'h0000_0206 -> PCF=32'h204, MisalignF=1 and stays 1 for 10 further cycles until reset.
- REQ-035: FlushD=1 and StallD=1 together -> bubble inserted (ValidD=0, InstrD=32'h13), FetchCnt unchanged.
- REQ-036: FetchCnt preloaded near wrap by running 2^WIDTH-1 loads (or WIDTH=8 instance, 255 loads) plus 1 more -> FetchCnt=0.
